dp_ram_fifo_ctrl: RTL
=====================

Name: dp_ram_fifo_ctrl

Overview:
Single-clock FIFO controller that owns both ports of the 16x16 dual-port RAM. Port A is the write side and port B is the read side; the controller tracks the pointers and occupancy. It exposes a push/pop interface to the producer and consumer, and turns the RAM's one-cycle registered read into a data/valid pair. It sits directly upstream of the RAM, driving its enables, write-enables, addresses and write data, and also consumes the RAM's port-B output. Both RAM clocks are tied to this block's clk.

Parameters:
DATA_W, 16, data width; must match the RAM word width.
ADDR_W, 4, RAM address width.
DEPTH, 16, number of entries; fixed at 2**ADDR_W.

Ports:
clk  in  1  single clock; rising edge; also drives the RAM's clka and clkb.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  push request.
wr_data  in  DATA_W  push data.
full  out  1  high when count==DEPTH.
rd_en  in  1  pop request.
rd_data  out  DATA_W  popped word; a pass-through of ram_outb.
rd_valid  out  1  high for one cycle when rd_data holds a newly popped word.
empty  out  1  high when count==0.
count  out  ADDR_W+1  current occupancy, 0..16.
ram_ena, ram_wea  out  1  RAM port A enable and write-enable.
ram_ada  out  ADDR_W  RAM port A address (write pointer).
ram_dina  out  DATA_W  RAM port A write data (wr_data).
ram_enb, ram_web  out  1  RAM port B enable and write-enable; ram_web is tied to 0.
ram_adb  out  ADDR_W  RAM port B address (read pointer).
ram_outb  in  DATA_W  RAM port B registered read data.

Behaviour:
- Reset (rst high at a clk edge):
  - wptr=0, rptr=0, count=0, rd_valid=0; hence empty=1, full=0.
  - RAM contents are not cleared.
  - While rst is high, ram_ena and ram_enb are forced to 0, so no push or pop is accepted.
- Accept conditions, evaluated from the state at cycle start:
  - push_ok = wr_en & ~full & ~rst.
  - pop_ok = rd_en & ~empty & ~rst.
- RAM drive (combinational, sampled by the RAM at the same edge):
  - ram_ena = ram_wea = push_ok; ram_ada = wptr; ram_dina = wr_data.
  - ram_enb = pop_ok; ram_adb = rptr; ram_web = 0.
- Pointers: wptr increments on push_ok and rptr increments on pop_ok. Both wrap modulo DEPTH (15 -> 0).
- count update:
  - +1 on push_ok only; -1 on pop_ok only.
  - Unchanged when both or neither are accepted.
- Simultaneous requests:
  - Empty, wr_en and rd_en both high: push accepted, pop rejected. count goes 0->1, rd_valid stays 0.
  - Full, wr_en and rd_en both high: pop accepted, push rejected. count goes 16->15.
  - 0<count<16 with both high: both accepted, count unchanged.
- No read/write collision is possible: wptr==rptr only when empty or full, and in those states one side is blocked.
- Read latency is 1 cycle:
  - rd_valid is registered as pop_ok.
  - rd_data = ram_outb is valid in the cycle after the accepted pop.
  - rd_data holds its last value until the next pop, because the RAM only updates its output on a read.
- Rejected requests are dropped silently; no pointer or count change.
- full and empty are decoded combinationally from count.
- Reset mid-stream: a pop accepted in the cycle before rst does not produce rd_valid after reset.

Optional Feature:
- Macro: FIFO_ERR_STICKY_EN.
- When defined:
  - Adds outputs ovf_err (1) and udf_err (1), both registered and reset to 0.
  - ovf_err sets on wr_en & full & ~rst; udf_err sets on rd_en & empty & ~rst.
  - Once set, each stays high until rst.
- When undefined: the ports and logic are absent, and rejected requests leave no trace.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, count=0, rd_valid=0, ram_ena=ram_enb=0.
- Push 0x1111,0x2222,0x3333, then pop 3 times -> rd_valid on the cycle after each pop; rd_data=0x1111,0x2222,0x3333; count ends at 0 with empty=1.
- Push 16 words 0xA000..0xA00F, then a 17th push 0xBEEF -> full=1, count=16, ram_ena=0 on the 17th. With FIFO_ERR_STICKY_EN, ovf_err=1.
- Drain all 16 words -> data 0xA000..0xA00F in order, confirming wptr/rptr wrap 15->0. A further pop when empty gives no rd_valid and sets udf_err under the macro.
- Simultaneous wr_en & rd_en at count=0, then at count=16, then at count=5 -> count goes 0->1, 16->15, 5->5; order is preserved.
- Assert rst after 4 pushes with a pop in flight -> next cycle count=0, empty=1, rd_valid=0, and sticky errors cleared.

Source files
------------

// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl
// Single-clock FIFO controller that owns both ports of a 16x16 dual-port RAM.
// Port A of the RAM is the write side and port B is the read side. The block
// keeps the write/read pointers and the occupancy count. It also turns the RAM's
// one-cycle registered read into a rd_data/rd_valid pair.
//
// Optional feature: define FIFO_ERR_STICKY_EN to add the sticky overflow and
// underflow flags ovf_err_o and udf_err_o.
//
// Ports
//   clk_i       clock; also drives the RAM's clka/clkb
//   rst_i       synchronous active-high reset
//   wr_en_i     push request
//   wr_data_i   push data
//   full_o      count == DEPTH
//   rd_en_i     pop request
//   rd_data_o   popped word (pass-through of ram_outb_i)
//   rd_valid_o  one-cycle strobe, rd_data_o holds a newly popped word
//   empty_o     count == 0
//   count_o     occupancy 0..DEPTH
//   ovf_err_o   (FIFO_ERR_STICKY_EN) sticky push-while-full flag
//   udf_err_o   (FIFO_ERR_STICKY_EN) sticky pop-while-empty flag
//   ram_ena_o, ram_wea_o, ram_ada_o, ram_dina_o    RAM port A (write)
//   ram_enb_o, ram_web_o, ram_adb_o                RAM port B (read)
//   ram_outb_i  RAM port B registered read data
module dp_ram_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              full_o,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
`ifdef FIFO_ERR_STICKY_EN
    output logic              ovf_err_o,
    output logic              udf_err_o,
`endif
    output logic              ram_ena_o,
    output logic              ram_wea_o,
    output logic [ADDR_W-1:0] ram_ada_o,
    output logic [DATA_W-1:0] ram_dina_o,
    output logic              ram_enb_o,
    output logic              ram_web_o,
    output logic [ADDR_W-1:0] ram_adb_o,
    input  logic [DATA_W-1:0] ram_outb_i
);

    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Reset gates both accepts so the RAM is never enabled while rst_i is high.
    assign push_ok = wr_en_i & ~full_o  & ~rst_i;
    assign pop_ok  = rd_en_i & ~empty_o & ~rst_i;

    assign ram_ena_o  = push_ok;
    assign ram_wea_o  = push_ok;
    assign ram_ada_o  = wptr_q;
    assign ram_dina_o = wr_data_i;
    assign ram_enb_o  = pop_ok;
    assign ram_web_o  = 1'b0;
    assign ram_adb_o  = rptr_q;

    // The RAM only refreshes its output on a read, so rd_data holds between pops.
    assign rd_data_o  = ram_outb_i;
    assign rd_valid_o = rd_valid_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // Pointers are exactly ADDR_W bits wide, so the increment wraps at DEPTH.
        if (push_ok) wptr_d = wptr_q + PTR_ONE;
        if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= pop_ok;
        end
    end

`ifdef FIFO_ERR_STICKY_EN
    logic ovf_err_q, ovf_err_d;
    logic udf_err_q, udf_err_d;

    always_comb begin
        ovf_err_d = ovf_err_q | (wr_en_i & full_o);
        udf_err_d = udf_err_q | (rd_en_i & empty_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign ovf_err_o = ovf_err_q;
    assign udf_err_o = udf_err_q;
`endif

endmodule
